// File: rtl/spi_frame_rx.sv
// SPI display-frame receiver: synchronizes raw SPI pins into clk, assembles MSB-first
// bytes and emits screen-RAM writes. Define SPI_FRAME_CHECKSUM_EN to add frame_err.
module spi_frame_rx #(
  parameter int unsigned             FRAME_BYTES = 7168,
  parameter int unsigned             ADDR_W      = 13,
  parameter logic [ADDR_W-1:0]       BORDER_ADDR = 13'h1B80,
  parameter int unsigned             SYNC_STAGES = 2,
  parameter logic [2:0]              BORDER_RST  = 3'b101
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_dat,
  input  logic              spi_cs,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [2:0]        border,
  output logic              frame_done,
  output logic              busy
`ifdef SPI_FRAME_CHECKSUM_EN
  ,
  output logic              frame_err
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync, cs_sync;
  logic                   s_clk, s_dat, s_cs, s_clk_d, s_cs_d;
  logic                   rise, cs_rise;
  logic [3:0]             bit_cnt;
  logic [7:0]             shift;

  // Equal-depth chains keep data aligned with the sampled clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= '0;
      dat_sync <= '0;
      cs_sync  <= '1;
      s_clk_d  <= 1'b0;
      s_cs_d   <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], spi_dat};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      s_clk_d  <= s_clk;
      s_cs_d   <= s_cs;
    end
  end

  assign s_clk   = clk_sync[SYNC_STAGES-1];
  assign s_dat   = dat_sync[SYNC_STAGES-1];
  assign s_cs    = cs_sync[SYNC_STAGES-1];
  assign rise    = s_clk & ~s_clk_d;
  assign cs_rise = s_cs & ~s_cs_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A full byte waits one cycle at bit_cnt==8 before COMMIT, so a coincident cs rise still discards it.
  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (!s_cs) state_nxt = SHIFT;
        SHIFT:   if (bit_cnt == 4'd8) state_nxt = COMMIT;
        COMMIT:  state_nxt = SHIFT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      shift      <= '0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      wr_addr    <= '0;
      border     <= BORDER_RST;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy       <= ~s_cs;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (state == COMMIT && !cs_rise) begin
        wr_en   <= 1'b1;
        wr_data <= shift;
      end
      // wr_addr holds the written address during the strobe and advances afterwards.
      if (wr_en) begin
        if (wr_addr == BORDER_ADDR) border <= wr_data[2:0];
        if (wr_addr == LAST_ADDR) begin
          wr_addr    <= '0;
          frame_done <= 1'b1;
        end else begin
          wr_addr <= wr_addr + ADDR_W'(1);
        end
      end
      if (cs_rise) begin
        wr_addr <= '0;
        bit_cnt <= '0;
        shift   <= '0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            shift   <= '0;
          end
          SHIFT: begin
            if (rise && bit_cnt != 4'd8) begin
              shift   <= {shift[6:0], s_dat};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          COMMIT:  bit_cnt <= '0;
          default: bit_cnt <= '0;
        endcase
      end
    end
  end

`ifdef SPI_FRAME_CHECKSUM_EN
  logic [7:0] xor_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_acc   <= '0;
      frame_err <= 1'b0;
    end else if (wr_en && wr_addr == LAST_ADDR) begin
      frame_err <= (wr_data != xor_acc);
      xor_acc   <= '0;
    end else if (cs_rise) begin
      xor_acc <= '0;
    end else if (wr_en) begin
      xor_acc <= xor_acc ^ wr_data;
    end
  end
`endif

endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
- Receives the host's SPI display frame in the LCD pixel-clock domain and turns it into byte writes for the dual-port screen RAM.
- The frame is 6144 ZX pixel bytes, then 768 attribute bytes, then 256 info bytes.
- Oversamples spi_clk/spi_dat/spi_cs through synchronizers, assembles bytes MSB-first, generates the RAM write address, captures the border colour register and flags frame completion.
- Sits directly upstream of the dual-port RAM write port and the border-colour mux.

Parameters:
FRAME_BYTES, 7168, bytes per frame (6144 + 768 + 256)
ADDR_W, 13, width of wr_addr
BORDER_ADDR, 13'h1B80, frame byte index whose low 3 bits are the border colour
SYNC_STAGES, 2, flip-flop depth of the input synchronizers (legal range 2..3)
BORDER_RST, 3'b101, reset value of border

Ports:
clk  in  1  system clock (LCD_CLK); must be at least 4x spi_clk
rst  in  1  asynchronous, active-high reset
spi_clk  in  1  raw SPI clock, idle low, data sampled on rising edge
spi_dat  in  1  raw SPI MOSI
spi_cs  in  1  raw chip select, active low
wr_en  out  1  one-cycle RAM write strobe
wr_addr  out  ADDR_W  RAM byte address 0..FRAME_BYTES-1
wr_data  out  8  assembled byte
border  out  3  border colour {G,R,B} as sent
frame_done  out  1  one-cycle pulse after byte FRAME_BYTES-1 is written
busy  out  1  high while synchronized cs is low

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, border=BORDER_RST, frame_done=0, busy=0.
- Synchronizers and state also reset, to sclk=0 and cs=1 (inactive).
- spi_clk, spi_dat and spi_cs each pass through SYNC_STAGES flops of identical depth, so data stays aligned to the clock edge.
- Rising edge detect: rise = s_clk & ~s_clk_d.
- State machine:
  - IDLE: s_cs=1; bit_cnt=0, shift register cleared. Goes to SHIFT when s_cs falls.
  - SHIFT: on each rise, shift = {shift[6:0], s_dat} and bit_cnt++. On the 8th rise, go to COMMIT.
  - COMMIT: lasts one cycle. Drives wr_en=1, wr_data=byte, wr_addr=current address, then returns to SHIFT with bit_cnt=0.
- Latency: wr_en is high exactly SYNC_STAGES+2 clk cycles after the first clk edge that samples the 8th raw spi_clk high.
- Address counter:
  - Increments the cycle after each COMMIT.
  - At FRAME_BYTES-1 it wraps to 0, and frame_done pulses in the same cycle as the wrap.
- Border: when COMMIT writes wr_addr==BORDER_ADDR, border <= byte[2:0] on the following cycle. The border byte is also written to RAM.
- A rise while in COMMIT cannot occur, given the 4x clock ratio. If it does, it is ignored; the bench checks nothing in this case.
- cs rising (s_cs 0->1) in any state:
  - Returns to IDLE and sets wr_addr=0 and bit_cnt=0.
  - A partial byte is discarded; no wr_en.
  - If the synchronized cs rise and the 8th rise arrive in the same cycle, cs wins and the byte is discarded.
  - Every new transaction starts at address 0.
- busy = ~s_cs, registered.
- Reset mid-byte: all state returns to reset values immediately (asynchronous); no spurious wr_en on release.

Optional Feature:
- Macro SPI_FRAME_CHECKSUM_EN adds output frame_err (1 bit, reset 0).
- With the macro:
  - The block keeps a running XOR of bytes 0..FRAME_BYTES-2.
  - Byte FRAME_BYTES-1 is compared to that XOR. frame_err is registered with frame_done: 1 on mismatch, 0 on match.
  - The XOR clears on wrap and on cs rise.
  - The last byte is still written to RAM.
- Without the macro: no frame_err port and no XOR logic.

Test Plan:
- After reset release with cs=1 and no SPI activity -> border=3'b101, wr_en never asserts, busy=0.
- cs low, send bytes 0xA5 then 0x3C at clk/8 SPI rate -> wr_en pulses twice, with (addr 0, 0xA5) then (addr 1, 0x3C). Each pulse is SYNC_STAGES+2 cycles after the 8th spi_clk rise.
- Full 7168-byte frame with byte 0x1B80=0xFA -> border=3'b010 one cycle after that write. frame_done is a single pulse after the 7168th byte, and wr_addr returns to 0.
- cs raised after 5 bits, then a new transaction sending 0x81 -> no write for the partial byte; 0x81 is written at addr 0.
- rst asserted mid-byte (bit 4 of byte 100), released, full byte 0x55 sent -> write of 0x55 at addr 0; no other wr_en.
- (SPI_FRAME_CHECKSUM_EN) frame whose last byte equals the XOR of the preceding bytes -> frame_err=0. Same frame with one payload byte flipped -> frame_err=1 together with frame_done.
